// File: rtl/ov7670_stream_gen.sv
// Frame-buffer reader that replays RGB444 pixels as an OV7670-style DVP byte stream
// (vsync/href/d, two bytes per pixel), used as a camera stand-in for capture-path tests.
module ov7670_stream_gen #(
  parameter int unsigned H_ACTIVE      = 320,
  parameter int unsigned V_ACTIVE      = 240,
  parameter int unsigned H_BLANK       = 144,
  parameter int unsigned VSYNC_LINES   = 3,
  parameter int unsigned V_BACK_LINES  = 17,
  parameter int unsigned V_FRONT_LINES = 10
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        en,
  output logic [16:0] rd_addr,
  output logic        rd_en,
  input  logic [11:0] rd_data,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  d,
  output logic        busy,
  output logic        frame_done
);

  localparam int unsigned Line     = 2 * H_ACTIVE + H_BLANK;
  localparam int unsigned MaxA     = (V_ACTIVE > VSYNC_LINES) ? V_ACTIVE : VSYNC_LINES;
  localparam int unsigned MaxB     = (V_BACK_LINES > V_FRONT_LINES) ? V_BACK_LINES : V_FRONT_LINES;
  localparam int unsigned MaxLines = (MaxA > MaxB) ? MaxA : MaxB;
  localparam int unsigned CW       = $clog2(Line + 1);
  localparam int unsigned LW       = $clog2(MaxLines + 1);

  localparam logic [CW-1:0] CycLast      = CW'(Line - 1);
  localparam logic [CW-1:0] CycPrefetch  = CW'(Line - 2);
  localparam logic [CW-1:0] CycHrefEnd   = CW'(2 * H_ACTIVE);
  localparam logic [CW-1:0] CycFetchEnd  = CW'(2 * H_ACTIVE - 2);
  localparam logic [LW-1:0] VsyncLast    = LW'(VSYNC_LINES - 1);
  localparam logic [LW-1:0] VbackLast    = LW'(V_BACK_LINES - 1);
  localparam logic [LW-1:0] ActiveLast   = LW'(V_ACTIVE - 1);
  localparam logic [LW-1:0] VfrontLast   = LW'(V_FRONT_LINES - 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StVsync  = 3'd1;
  localparam logic [2:0] StVback  = 3'd2;
  localparam logic [2:0] StActive = 3'd3;
  localparam logic [2:0] StVfront = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [LW-1:0] line_q, line_d;
  logic [16:0]   addr_q;
  logic [7:0]    pix_q;
  logic          lat_q;
  logic          last_line, done_d, href_d, fetch_d, pre_line;
  logic [7:0]    d_d;

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    line_d    = line_q;
    done_d    = 1'b0;
    last_line = 1'b0;
    case (state_q)
      StVsync:  last_line = (line_q == VsyncLast);
      StVback:  last_line = (line_q == VbackLast);
      StActive: last_line = (line_q == ActiveLast);
      StVfront: last_line = (line_q == VfrontLast);
      default:  last_line = 1'b0;
    endcase

    if (state_q == StIdle) begin
      if (en) state_d = StVsync;
    end else if (cyc_q == CycLast) begin
      cyc_d = '0;
      if (last_line) begin
        line_d = '0;
        case (state_q)
          StVsync:  state_d = StVback;
          StVback:  state_d = StActive;
          StActive: state_d = StVfront;
          StVfront: begin
            state_d = en ? StVsync : StIdle;
            done_d  = 1'b1;
          end
          default:  state_d = StIdle;
        endcase
      end else begin
        line_d = line_q + 1'b1;
      end
    end else begin
      cyc_d = cyc_q + 1'b1;
    end
  end

  // Outputs are decoded from the next position so the registers line up with it.
  always_comb begin
    href_d   = (state_d == StActive) && (cyc_d < CycHrefEnd);
    pre_line = ((state_d == StVback) && (line_d == VbackLast)) ||
               ((state_d == StActive) && (line_d != ActiveLast));
    // Pixel x is fetched two cycles ahead of its even byte; pixel 0 comes from the prior line.
    fetch_d  = ((state_d == StActive) && (cyc_d < CycFetchEnd) && !cyc_d[0]) ||
               ((cyc_d == CycPrefetch) && pre_line);
    if (!href_d) begin
      d_d = 8'h00;
    end else if (lat_q) begin
      d_d = {4'h0, rd_data[11:8]};
    end else begin
      d_d = pix_q;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cyc_q      <= '0;
      line_q     <= '0;
      addr_q     <= '0;
      pix_q      <= '0;
      lat_q      <= 1'b0;
      rd_addr    <= '0;
      rd_en      <= 1'b0;
      vsync      <= 1'b0;
      href       <= 1'b0;
      d          <= 8'h00;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      line_q     <= line_d;
      lat_q      <= rd_en;
      if (lat_q) pix_q <= rd_data[7:0];
      rd_en      <= fetch_d;
      if (fetch_d) begin
        rd_addr <= addr_q;
        addr_q  <= addr_q + 1'b1;
      end else if ((state_d == StVsync) || (state_d == StIdle)) begin
        addr_q  <= '0;
      end
      vsync      <= (state_d == StVsync);
      href       <= href_d;
      d          <= d_d;
      busy       <= (state_d != StIdle);
      frame_done <= done_d;
    end
  end

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Directed bench for ov7670_stream_gen with small geometry: LINE=12, 72 cycles per frame.
module tb_ov7670_stream_gen;

  logic        pclk, rst_n, en;
  logic [16:0] rd_addr;
  logic        rd_en;
  logic [11:0] rd_data;
  logic        vsync, href;
  logic [7:0]  d;
  logic        busy, frame_done;

  int n_tests = 0;
  int n_fail  = 0;

  ov7670_stream_gen #(
    .H_ACTIVE(4), .V_ACTIVE(3), .H_BLANK(4),
    .VSYNC_LINES(1), .V_BACK_LINES(1), .V_FRONT_LINES(1)
  ) dut (
    .pclk(pclk), .rst_n(rst_n), .en(en),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
    .vsync(vsync), .href(href), .d(d),
    .busy(busy), .frame_done(frame_done)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  function automatic logic [11:0] ram_word(input logic [16:0] a);
    if (a == 17'd5) return 12'hABC;
    return {a[3:0] + 4'd1, a[3:0] ^ 4'h7, a[3:0]};
  endfunction

  always_ff @(posedge pclk) if (rd_en) rd_data <= ram_word(rd_addr);

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  // Running stream model, advanced once per cycle at the falling edge.
  int          cyc_n = 0, vs_rises = 0, done_cnt = 0, rd_cnt = 0;
  logic        vs_prev = 1'b0, hphase = 1'b0, en_h1 = 1'b0, en_h2 = 1'b0;
  logic [11:0] w_h1 = '0, w_h2 = '0, cur_w = '0;
  logic [16:0] exp_addr = '0;

  task automatic monitor();
    logic        even;
    logic [11:0] w_new;
    w_new = '0;
    cyc_n++;
    if (vsync && !vs_prev) begin
      vs_rises++;
      exp_addr = '0;
    end
    vs_prev = vsync;
    if (frame_done) done_cnt++;
    if (rd_en) rd_cnt++;
    if (!rst_n) begin
      en_h1  = 1'b0;
      en_h2  = 1'b0;
      hphase = 1'b0;
    end else begin
      even = href && !hphase;
      check("fetch_lead", 32'(even), 32'(en_h2));
      if (!href) begin
        check("d_zero_blank", 32'(d), 32'd0);
      end else if (even) begin
        cur_w = w_h2;
        check("d_even_byte", 32'(d), 32'({4'h0, cur_w[11:8]}));
      end else begin
        check("d_odd_byte", 32'(d), 32'(cur_w[7:0]));
      end
      if (rd_en) begin
        check("rd_addr_seq", 32'(rd_addr), 32'(exp_addr));
        w_new    = ram_word(exp_addr);
        exp_addr = exp_addr + 17'd1;
      end
      hphase = href ? !hphase : 1'b0;
      w_h2   = w_h1;
      w_h1   = w_new;
      en_h2  = en_h1;
      en_h1  = rd_en;
    end
  endtask

  task automatic tick();
    @(negedge pclk);
    monitor();
  endtask

  typedef struct {
    int          p;
    logic        vs;
    logic        hr;
    logic [7:0]  dv;
    logic        re;
    logic [16:0] a;
    logic        ca;
    logic        bz;
    logic        fd;
  } vec_t;

  function automatic vec_t mk(int p, logic vs, logic hr, logic [7:0] dv, logic re,
                              logic [16:0] a, logic ca, logic bz, logic fd);
    vec_t v;
    v.p = p; v.vs = vs; v.hr = hr; v.dv = dv; v.re = re;
    v.a = a; v.ca = ca; v.bz = bz; v.fd = fd;
    return v;
  endfunction

  function automatic vec_t snap(int p);
    return mk(p, vsync, href, d, rd_en, rd_addr, 1'b1, busy, frame_done);
  endfunction

  vec_t tbl[22];
  vec_t obs[80];

  initial begin
    logic quiet, found, hr_prev;
    int   r0, dn0, rc0, k, last, vs_n, hr_n, re_n, fd_n, bursts;
    int   rt[3];

    // Frame position p = cycles since vsync rise; words from ram_word().
    //            p   vs    hr    d      rd_en addr    chk   busy  done
    tbl[0]  = mk( 0, 1'b1, 1'b0, 8'h00, 1'b0, 17'd0,  1'b0, 1'b1, 1'b0);
    tbl[1]  = mk(11, 1'b1, 1'b0, 8'h00, 1'b0, 17'd0,  1'b0, 1'b1, 1'b0);
    tbl[2]  = mk(12, 1'b0, 1'b0, 8'h00, 1'b0, 17'd0,  1'b0, 1'b1, 1'b0);
    tbl[3]  = mk(21, 1'b0, 1'b0, 8'h00, 1'b0, 17'd0,  1'b0, 1'b1, 1'b0);
    tbl[4]  = mk(22, 1'b0, 1'b0, 8'h00, 1'b1, 17'd0,  1'b1, 1'b1, 1'b0);
    tbl[5]  = mk(23, 1'b0, 1'b0, 8'h00, 1'b0, 17'd0,  1'b0, 1'b1, 1'b0);
    tbl[6]  = mk(24, 1'b0, 1'b1, 8'h01, 1'b1, 17'd1,  1'b1, 1'b1, 1'b0);
    tbl[7]  = mk(25, 1'b0, 1'b1, 8'h70, 1'b0, 17'd0,  1'b0, 1'b1, 1'b0);
    tbl[8]  = mk(31, 1'b0, 1'b1, 8'h43, 1'b0, 17'd0,  1'b0, 1'b1, 1'b0);
    tbl[9]  = mk(32, 1'b0, 1'b0, 8'h00, 1'b0, 17'd0,  1'b0, 1'b1, 1'b0);
    tbl[10] = mk(34, 1'b0, 1'b0, 8'h00, 1'b1, 17'd4,  1'b1, 1'b1, 1'b0);
    tbl[11] = mk(36, 1'b0, 1'b1, 8'h05, 1'b1, 17'd5,  1'b1, 1'b1, 1'b0);
    tbl[12] = mk(38, 1'b0, 1'b1, 8'h0A, 1'b1, 17'd6,  1'b1, 1'b1, 1'b0);
    tbl[13] = mk(39, 1'b0, 1'b1, 8'hBC, 1'b0, 17'd0,  1'b0, 1'b1, 1'b0);
    tbl[14] = mk(40, 1'b0, 1'b1, 8'h07, 1'b1, 17'd7,  1'b1, 1'b1, 1'b0);
    tbl[15] = mk(46, 1'b0, 1'b0, 8'h00, 1'b1, 17'd8,  1'b1, 1'b1, 1'b0);
    tbl[16] = mk(52, 1'b0, 1'b1, 8'h0B, 1'b1, 17'd11, 1'b1, 1'b1, 1'b0);
    tbl[17] = mk(58, 1'b0, 1'b0, 8'h00, 1'b0, 17'd0,  1'b0, 1'b1, 1'b0);
    tbl[18] = mk(60, 1'b0, 1'b0, 8'h00, 1'b0, 17'd0,  1'b0, 1'b1, 1'b0);
    tbl[19] = mk(71, 1'b0, 1'b0, 8'h00, 1'b0, 17'd0,  1'b0, 1'b1, 1'b0);
    tbl[20] = mk(72, 1'b0, 1'b0, 8'h00, 1'b0, 17'd0,  1'b0, 1'b0, 1'b1);
    tbl[21] = mk(73, 1'b0, 1'b0, 8'h00, 1'b0, 17'd0,  1'b0, 1'b0, 1'b0);

    // Reset and idle
    rst_n = 1'b1;
    en    = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("reset_outputs", 32'({vsync, href, d, rd_en, busy, frame_done}), 32'd0);
    check("reset_rd_addr", 32'(rd_addr), 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    quiet = 1'b0;
    repeat (50) begin
      tick();
      quiet = quiet | busy | vsync | href | rd_en | frame_done | (d != 8'h00) | (rd_addr != '0);
    end
    check("idle_quiet", 32'(quiet), 32'd0);

    // Single frame from a one-cycle en pulse
    check("pre_start_vsync", 32'(vsync), 32'd0);
    en = 1'b1;
    tick();
    en = 1'b0;
    obs[0] = snap(0);
    check("start_latency", 32'({vsync, busy}), 32'b11);
    for (int p = 1; p < 80; p++) begin
      tick();
      obs[p] = snap(p);
    end
    for (int i = 0; i < 22; i++) begin
      vec_t e, o;
      e = tbl[i];
      o = obs[e.p];
      check($sformatf("vec_p%0d", e.p),
            {2'b00, o.vs, o.hr, o.dv, o.re, o.bz, o.fd, (e.ca ? o.a : 17'd0)},
            {2'b00, e.vs, e.hr, e.dv, e.re, e.bz, e.fd, (e.ca ? e.a : 17'd0)});
    end
    vs_n = 0; hr_n = 0; re_n = 0; fd_n = 0; bursts = 0; hr_prev = 1'b0;
    for (int p = 0; p < 80; p++) begin
      vs_n += int'(obs[p].vs);
      hr_n += int'(obs[p].hr);
      re_n += int'(obs[p].re);
      fd_n += int'(obs[p].fd);
      if (obs[p].hr && !hr_prev) bursts++;
      hr_prev = obs[p].hr;
    end
    check("vsync_cycles", 32'(vs_n), 32'd12);
    check("href_cycles", 32'(hr_n), 32'd24);
    check("href_bursts", 32'(bursts), 32'd3);
    check("rd_en_pulses", 32'(re_n), 32'd12);
    check("frame_done_pulses", 32'(fd_n), 32'd1);

    // Continuous frames, then en dropped during the third frame's ACTIVE lines
    r0 = vs_rises; dn0 = done_cnt; rc0 = rd_cnt; k = 0; last = vs_rises;
    rt[0] = 0; rt[1] = 0; rt[2] = 0;
    en = 1'b1;
    for (int i = 0; i < 300 && vs_rises < r0 + 3; i++) begin
      tick();
      if (vs_rises != last && k < 3) begin
        rt[k] = cyc_n;
        k++;
        last = vs_rises;
      end
    end
    check("cont_three_rises", 32'(vs_rises - r0), 32'd3);
    check("cont_period_1", 32'(rt[1] - rt[0]), 32'd72);
    check("cont_period_2", 32'(rt[2] - rt[1]), 32'd72);
    repeat (30) tick();
    check("drop_point_active", 32'(href), 32'd1);
    en = 1'b0;
    for (int i = 0; i < 200 && busy; i++) tick();
    check("drop_returns_idle", 32'(busy), 32'd0);
    repeat (100) tick();
    check("drop_no_extra_vsync", 32'(vs_rises - r0), 32'd3);
    check("cont_frame_done", 32'(done_cnt - dn0), 32'd3);
    check("cont_reads", 32'(rd_cnt - rc0), 32'd36);

    // Asynchronous reset in the middle of an active line
    en    = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      found = href && rd_en;
    end
    check("rst_point_found", 32'(found), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_outputs", 32'({href, rd_en, d, vsync, busy}), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 100 && !rd_en; i++) tick();
    check("rst_restart_fetch", 32'(rd_en), 32'd1);
    check("rst_restart_addr", 32'(rd_addr), 32'd0);
    en = 1'b0;
    for (int i = 0; i < 200 && busy; i++) tick();
    check("rst_frame_completes", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
